tone_sequencer: RTL and testbench

Parametrised successor to the single-voice switch-selected tone divider. Generates a square-wave tone from the system clock using a divisor table computed from CLK_FREQ. Operates in manual mode (note held from switches) or sequence mode (plays all NUM_NOTES notes in order, each for NOTE_MS, with optional looping). Note changes are glitch-free. Output drives the audio/speaker pin.

---
 rtl/tone_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_tone_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/tone_sequencer.sv
// tone_sequencer: square-wave tone generator with a manual and a sequence mode.
//
// Divisors for the eight notes are elaborated from CLK_FREQ. In manual mode the note
// follows note_sel while enable is high. In sequence mode the eight notes play in order,
// NOTE_MS each, optionally looping. A new divisor only takes effect at a toggle of
// outCLK, so a note change never shortens or stretches a half-period.
//
// Ports:
//   CLOCK_50M  in   system clock
//   reset      in   synchronous active-high reset
//   mode       in   0 = manual, 1 = sequence
//   enable     in   manual: tone on while high
//   note_sel   in   manual: note index 0..7
//   start      in   sequence: level-sampled start request
//   loop       in   sequence: wrap to note 0 after note 7
//   outCLK     out  square-wave tone
//   busy       out  tone active
//   note_idx   out  index of the sounding note
//   done       out  one-cycle pulse when a non-looping sequence completes
module tone_sequencer #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned NOTE_MS  = 250,
    parameter int unsigned DIV_W    = 17,
    parameter int unsigned DUR_W    = 24
) (
    input  logic       CLOCK_50M,
    input  logic       reset,
    input  logic       mode,
    input  logic       enable,
    input  logic [2:0] note_sel,
    input  logic       start,
    input  logic       loop,
    output logic       outCLK,
    output logic       busy,
    output logic [2:0] note_idx,
    output logic       done
);

    // Half-period terminal counts: CLK_FREQ / (2 * f) - 1, truncated.
    localparam logic [DIV_W-1:0] HALF0 = DIV_W'(CLK_FREQ / (2 * 523) - 1);
    localparam logic [DIV_W-1:0] HALF1 = DIV_W'(CLK_FREQ / (2 * 587) - 1);
    localparam logic [DIV_W-1:0] HALF2 = DIV_W'(CLK_FREQ / (2 * 659) - 1);
    localparam logic [DIV_W-1:0] HALF3 = DIV_W'(CLK_FREQ / (2 * 698) - 1);
    localparam logic [DIV_W-1:0] HALF4 = DIV_W'(CLK_FREQ / (2 * 784) - 1);
    localparam logic [DIV_W-1:0] HALF5 = DIV_W'(CLK_FREQ / (2 * 880) - 1);
    localparam logic [DIV_W-1:0] HALF6 = DIV_W'(CLK_FREQ / (2 * 988) - 1);
    localparam logic [DIV_W-1:0] HALF7 = DIV_W'(CLK_FREQ / (2 * 1046) - 1);

    localparam logic [DUR_W-1:0] NOTE_CYC = DUR_W'(CLK_FREQ / 1000 * NOTE_MS - 1);

    function automatic logic [DIV_W-1:0] half_lut(input logic [2:0] idx);
        case (idx)
            3'd0:    return HALF0;
            3'd1:    return HALF1;
            3'd2:    return HALF2;
            3'd3:    return HALF3;
            3'd4:    return HALF4;
            3'd5:    return HALF5;
            3'd6:    return HALF6;
            default: return HALF7;
        endcase
    endfunction

    typedef enum logic [1:0] {StIdle, StManual, StPlay, StFinish} state_e;

    state_e           state_q;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cur_half_q;
    logic [DUR_W-1:0] dur_q;

    logic       half_hit;
    logic       dur_end;
    logic [2:0] seq_next_idx;

    assign half_hit = (cnt_q == cur_half_q);
    assign dur_end  = (dur_q == NOTE_CYC);

    // Note index in effect after this edge; a toggle on the same edge as a note
    // boundary picks up the new divisor immediately.
    always_comb begin
        seq_next_idx = note_idx;
        if (dur_end) begin
            seq_next_idx = (note_idx == 3'd7) ? 3'd0 : note_idx + 3'd1;
        end
    end

    always_ff @(posedge CLOCK_50M) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            cur_half_q <= '0;
            dur_q      <= '0;
            outCLK     <= 1'b0;
            busy       <= 1'b0;
            note_idx   <= 3'd0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    outCLK <= 1'b0;
                    busy   <= 1'b0;
                    cnt_q  <= '0;
                    dur_q  <= '0;
                    if (!mode && enable) begin
                        state_q    <= StManual;
                        busy       <= 1'b1;
                        note_idx   <= note_sel;
                        cur_half_q <= half_lut(note_sel);
                    end else if (mode && start) begin
                        state_q    <= StPlay;
                        busy       <= 1'b1;
                        note_idx   <= 3'd0;
                        cur_half_q <= HALF0;
                    end
                end

                StManual: begin
                    if (mode || !enable) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                        outCLK  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (half_hit) begin
                        outCLK     <= ~outCLK;
                        cnt_q      <= '0;
                        note_idx   <= note_sel;
                        cur_half_q <= half_lut(note_sel);
                    end else begin
                        cnt_q <= cnt_q + DIV_W'(1);
                    end
                end

                StPlay: begin
                    if (!mode) begin
                        // Abort: no done pulse.
                        state_q <= StIdle;
                        busy    <= 1'b0;
                        outCLK  <= 1'b0;
                        cnt_q   <= '0;
                        dur_q   <= '0;
                    end else begin
                        if (half_hit) begin
                            outCLK     <= ~outCLK;
                            cnt_q      <= '0;
                            cur_half_q <= half_lut(seq_next_idx);
                        end else begin
                            cnt_q <= cnt_q + DIV_W'(1);
                        end

                        if (dur_end) begin
                            dur_q <= '0;
                            if (note_idx == 3'd7 && !loop) begin
                                state_q <= StFinish;
                                done    <= 1'b1;
                                busy    <= 1'b0;
                                outCLK  <= 1'b0;
                                cnt_q   <= '0;
                            end else begin
                                note_idx <= seq_next_idx;
                            end
                        end else begin
                            dur_q <= dur_q + DUR_W'(1);
                        end
                    end
                end

                StFinish: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    outCLK  <= 1'b0;
                    cnt_q   <= '0;
                    dur_q   <= '0;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer at CLK_FREQ=100_000, NOTE_MS=1:
// NOTE_CYC=99, HALF = 94, 84, 74, 70, 62, 55, 49, 46.
module tb_tone_sequencer;

    logic       CLOCK_50M = 1'b0;
    logic       reset     = 1'b1;
    logic       mode      = 1'b0;
    logic       enable    = 1'b0;
    logic [2:0] note_sel  = 3'd0;
    logic       start     = 1'b0;
    logic       loop      = 1'b0;
    logic       outCLK;
    logic       busy;
    logic [2:0] note_idx;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;
    int period;

    tone_sequencer #(
        .CLK_FREQ(100_000),
        .NOTE_MS (1),
        .DIV_W   (17),
        .DUR_W   (24)
    ) dut (
        .CLOCK_50M(CLOCK_50M),
        .reset    (reset),
        .mode     (mode),
        .enable   (enable),
        .note_sel (note_sel),
        .start    (start),
        .loop     (loop),
        .outCLK   (outCLK),
        .busy     (busy),
        .note_idx (note_idx),
        .done     (done)
    );

    always #5 CLOCK_50M = ~CLOCK_50M;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLOCK_50M);
            #1;
        end
    endtask

    // Cycles until outCLK changes; returns max_cyc+1 if it never does.
    task automatic wait_toggle(input int max_cyc, output int n);
        logic prev;
        prev = outCLK;
        n = 0;
        do begin
            tick();
            n++;
        end while (outCLK == prev && n <= max_cyc);
    endtask

    initial begin
        // Power-on reset.
        tick(3);
        check("por_out", outCLK, 0);
        check("por_busy", busy, 0);
        check("por_idx", note_idx, 0);
        check("por_done", done, 0);
        reset = 1'b0;
        tick(2);
        check("idle_busy", busy, 0);

        // Manual mode, note 0.
        mode = 1'b0; note_sel = 3'd0; enable = 1'b1;
        tick();
        check("man_busy", busy, 1);
        check("man_idx", note_idx, 0);
        check("man_out0", outCLK, 0);
        wait_toggle(200, period);
        check("man_first_half", period, 95);
        check("man_out1", outCLK, 1);
        wait_toggle(200, period);
        check("man_second_half", period, 95);

        // Glitch-free change to note 7 mid half-period.
        tick(30);
        note_sel = 3'd7;
        tick();
        check("chg_idx_held", note_idx, 0);
        wait_toggle(200, period);
        check("chg_finish_half", period, 64);
        check("chg_idx_new", note_idx, 7);
        wait_toggle(200, period);
        check("chg_new_half_a", period, 47);
        wait_toggle(200, period);
        check("chg_new_half_b", period, 47);
        check("chg_out_high", outCLK, 1);

        // Dropping enable forces outCLK low.
        tick(10);
        enable = 1'b0;
        tick();
        check("drop_out", outCLK, 0);
        check("drop_busy", busy, 0);

        // Reset mid-tone on note 5.
        note_sel = 3'd5; enable = 1'b1;
        tick();
        check("n5_idx", note_idx, 5);
        wait_toggle(200, period);
        check("n5_half", period, 56);
        tick(10);
        reset = 1'b1;
        tick();
        check("rst_out", outCLK, 0);
        check("rst_busy", busy, 0);
        check("rst_idx", note_idx, 0);
        tick(2);
        check("rst_done", done, 0);
        enable = 1'b0; reset = 1'b0;
        tick();
        check("rst_rel_busy", busy, 0);

        // Sequence, no loop.
        mode = 1'b1; loop = 1'b0; note_sel = 3'd3; start = 1'b1;
        tick();
        start = 1'b0;
        check("seq_busy", busy, 1);
        check("seq_idx0", note_idx, 0);
        tick(50);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("seq_idx_%0d", i), note_idx, i);
            check($sformatf("seq_done_%0d", i), done, 0);
            if (i < 7) tick(100);
        end
        tick(49);
        check("seq_last_busy", busy, 1);
        check("seq_last_done", done, 0);
        tick();
        check("seq_done_pulse", done, 1);
        check("seq_fin_busy", busy, 0);
        check("seq_fin_out", outCLK, 0);
        tick();
        check("seq_done_once", done, 0);
        tick(5);
        check("seq_after_busy", busy, 0);
        check("seq_after_out", outCLK, 0);
        check("seq_after_done", done, 0);

        // Looping sequence, then abort by clearing mode.
        loop = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(750);
        check("loop_idx7", note_idx, 7);
        tick(50);
        check("loop_wrap_idx", note_idx, 0);
        check("loop_no_done", done, 0);
        check("loop_busy", busy, 1);
        tick(50);
        check("loop_idx0_mid", note_idx, 0);
        mode = 1'b0;
        tick();
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_out", outCLK, 0);
        tick();
        check("abort_done_late", done, 0);

        // Restart with start held through FINISH.
        mode = 1'b1; loop = 1'b0; start = 1'b1;
        tick();
        check("rs_busy", busy, 1);
        tick(799);
        check("rs_pre_done", done, 0);
        tick();
        check("rs_done", done, 1);
        tick();
        check("rs_idle_busy", busy, 0);
        tick();
        check("rs_restart_busy", busy, 1);
        check("rs_restart_idx", note_idx, 0);
        start = 1'b0; mode = 1'b0;
        tick(2);
        check("rs_end_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
